// File: rtl/de_pipe_reg.sv
// D/E pipeline register with flush, hazard-stall bubble insertion
// and a saturating stall-cycle counter.
module de_pipe_reg (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_Instr,
  input  logic [31:0] D_RS,
  input  logic [31:0] D_RT,
  input  logic [31:0] D_Ext,
  input  logic [3:0]  D_MDType,
  input  logic [4:0]  D_ExcCode,
  input  logic        D_BD,
  input  logic        D_DataStall,
  input  logic        E_Start,
  input  logic        E_Busy,
  output logic [31:0] E_PC,
  output logic [31:0] E_Instr,
  output logic [31:0] E_RS,
  output logic [31:0] E_RT,
  output logic [31:0] E_Ext,
  output logic [3:0]  E_MDType,
  output logic [4:0]  E_ExcCode,
  output logic        E_BD,
  output logic        E_Valid,
  output logic        StallFD,
  output logic [15:0] StallCount
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [3:0]  MD_NONE  = 4'd0;

  logic md_stall;

  // Non-MD instructions never wait on the mult/div unit.
  assign md_stall = (D_MDType != MD_NONE) && (E_Start || E_Busy);
  assign StallFD  = md_stall || D_DataStall;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      E_PC      <= RESET_PC;
      E_Instr   <= '0;
      E_RS      <= '0;
      E_RT      <= '0;
      E_Ext     <= '0;
      E_MDType  <= '0;
      E_ExcCode <= '0;
      E_BD      <= 1'b0;
      E_Valid   <= 1'b0;
    end else if (Req) begin
      E_PC      <= EXC_PC;
      E_Instr   <= '0;
      E_RS      <= '0;
      E_RT      <= '0;
      E_Ext     <= '0;
      E_MDType  <= '0;
      E_ExcCode <= '0;
      E_BD      <= 1'b0;
      E_Valid   <= 1'b0;
    end else if (StallFD) begin
      // Bubble keeps PC/BD so a later exception reports the right EPC.
      E_PC      <= D_PC;
      E_Instr   <= '0;
      E_RS      <= '0;
      E_RT      <= '0;
      E_Ext     <= '0;
      E_MDType  <= '0;
      E_ExcCode <= '0;
      E_BD      <= D_BD;
      E_Valid   <= 1'b0;
    end else begin
      E_PC      <= D_PC;
      E_Instr   <= D_Instr;
      E_RS      <= D_RS;
      E_RT      <= D_RT;
      E_Ext     <= D_Ext;
      E_MDType  <= D_MDType;
      E_ExcCode <= D_ExcCode;
      E_BD      <= D_BD;
      E_Valid   <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCount <= '0;
    end else if (StallFD && (StallCount != 16'hFFFF)) begin
      StallCount <= StallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_de_pipe_reg.sv
// Scoreboard bench for de_pipe_reg: expected E-stage state pushed
// per edge, popped and compared by a monitor after the edge.
module tb_de_pipe_reg;

  logic        Clk;
  logic        Reset;
  logic        Req;
  logic [31:0] D_PC, D_Instr, D_RS, D_RT, D_Ext;
  logic [3:0]  D_MDType;
  logic [4:0]  D_ExcCode;
  logic        D_BD, D_DataStall, E_Start, E_Busy;
  logic [31:0] E_PC, E_Instr, E_RS, E_RT, E_Ext;
  logic [3:0]  E_MDType;
  logic [4:0]  E_ExcCode;
  logic        E_BD, E_Valid, StallFD;
  logic [15:0] StallCount;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ext;
    logic [3:0]  md;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
    logic [15:0] sc;
  } e_t;

  e_t          sb[$];
  logic [15:0] mdl_sc;
  int          n_tests;
  int          n_fail;

  de_pipe_reg dut (
    .Clk(Clk), .Reset(Reset), .Req(Req),
    .D_PC(D_PC), .D_Instr(D_Instr), .D_RS(D_RS), .D_RT(D_RT),
    .D_Ext(D_Ext), .D_MDType(D_MDType), .D_ExcCode(D_ExcCode),
    .D_BD(D_BD), .D_DataStall(D_DataStall),
    .E_Start(E_Start), .E_Busy(E_Busy),
    .E_PC(E_PC), .E_Instr(E_Instr), .E_RS(E_RS), .E_RT(E_RT),
    .E_Ext(E_Ext), .E_MDType(E_MDType), .E_ExcCode(E_ExcCode),
    .E_BD(E_BD), .E_Valid(E_Valid),
    .StallFD(StallFD), .StallCount(StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Monitor: compare full E-stage state after every scored edge.
  always @(posedge Clk) begin
    e_t exp_v;
    e_t got;
    #1;
    if (sb.size() != 0) begin
      exp_v = sb.pop_front();
      got = {E_PC, E_Instr, E_RS, E_RT, E_Ext, E_MDType,
             E_ExcCode, E_BD, E_Valid, StallCount};
      n_tests++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL sb_state t=%0t got=%h exp=%h",
                 $time, got, exp_v);
      end
    end
  end

  task automatic push_exp();
    e_t x;
    logic st;
    st = ((D_MDType != 4'd0) && (E_Start || E_Busy)) || D_DataStall;
    x = '0;
    if (Reset) begin
      x.pc = 32'h0000_3000;
      mdl_sc = 16'd0;
    end else begin
      if (st && mdl_sc != 16'hFFFF) mdl_sc = mdl_sc + 16'd1;
      if (Req) begin
        x.pc = 32'h0000_4180;
      end else if (st) begin
        x.pc = D_PC;
        x.bd = D_BD;
      end else begin
        x.pc    = D_PC;
        x.instr = D_Instr;
        x.rs    = D_RS;
        x.rt    = D_RT;
        x.ext   = D_Ext;
        x.md    = D_MDType;
        x.exc   = D_ExcCode;
        x.bd    = D_BD;
        x.valid = 1'b1;
      end
    end
    x.sc = mdl_sc;
    sb.push_back(x);
  endtask

  task automatic step();
    push_exp();
    @(posedge Clk);
    #2;
  endtask

  task automatic rand_d();
    D_PC      = $urandom;
    D_Instr   = $urandom;
    D_RS      = $urandom;
    D_RT      = $urandom;
    D_Ext     = $urandom;
    D_MDType  = 4'($urandom_range(0, 8));
    D_ExcCode = 5'($urandom);
    D_BD      = 1'($urandom);
  endtask

  task automatic quiet();
    Reset = 0; Req = 0; D_DataStall = 0; E_Start = 0; E_Busy = 0;
  endtask

  task automatic test_reset();
    rand_d();
    Reset = 1; Req = 1; D_DataStall = 0; E_Start = 1; E_Busy = 1;
    step();
    step();
    n_tests++;
    if (E_PC !== 32'h3000 || E_Valid !== 1'b0 || StallCount !== 16'd0) begin
      n_fail++;
      $display("FAIL reset pc=%h valid=%b sc=%h exp 3000/0/0",
               E_PC, E_Valid, StallCount);
    end
  endtask

  task automatic test_capture();
    quiet();
    rand_d();
    D_PC = 32'h3004; D_Instr = 32'h0085_1021; D_MDType = 0;
    #1;
    n_tests++;
    if (StallFD !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_stallfd got=%b exp=0", StallFD);
    end
    step();
    n_tests++;
    if (E_PC !== 32'h3004 || E_Instr !== 32'h0085_1021 || E_Valid !== 1) begin
      n_fail++;
      $display("FAIL capture pc=%h instr=%h valid=%b exp 3004/00851021/1",
               E_PC, E_Instr, E_Valid);
    end
  endtask

  task automatic test_md_stall();
    quiet();
    rand_d();
    E_Busy = 1; D_MDType = 6; D_PC = 32'h3010; D_BD = 1;
    #1;
    n_tests++;
    if (StallFD !== 1'b1) begin
      n_fail++;
      $display("FAIL md_stallfd got=%b exp=1", StallFD);
    end
    step();
    n_tests++;
    if (E_Instr !== 0 || E_Valid !== 0 || E_PC !== 32'h3010 || E_BD !== 1) begin
      n_fail++;
      $display("FAIL md_bubble instr=%h valid=%b pc=%h bd=%b exp 0/0/3010/1",
               E_Instr, E_Valid, E_PC, E_BD);
    end
  endtask

  task automatic test_stall_release();
    logic [15:0] sc0;
    quiet();
    rand_d();
    D_MDType = 1; E_Busy = 1;
    sc0 = mdl_sc;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (E_Valid !== 1'b0) begin
        n_fail++;
        $display("FAIL release_bubble%0d valid=%b exp=0", i, E_Valid);
      end
    end
    E_Busy = 0;
    step();
    n_tests++;
    if (E_MDType !== 4'd1 || E_Valid !== 1 || E_PC !== D_PC ||
        StallCount !== sc0 + 16'd5) begin
      n_fail++;
      $display("FAIL release md=%0d valid=%b pc=%h sc=%h exp 1/1/%h/%h",
               E_MDType, E_Valid, E_PC, StallCount, D_PC, sc0 + 16'd5);
    end
  endtask

  task automatic test_busy_bypass();
    quiet();
    rand_d();
    E_Busy = 1; D_MDType = 0;
    #1;
    n_tests++;
    if (StallFD !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_stallfd got=%b exp=0", StallFD);
    end
    step();
    n_tests++;
    if (E_Valid !== 1 || E_Instr !== D_Instr) begin
      n_fail++;
      $display("FAIL bypass valid=%b instr=%h exp 1/%h",
               E_Valid, E_Instr, D_Instr);
    end
  endtask

  task automatic test_flush();
    logic [15:0] sc0;
    quiet();
    rand_d();
    Req = 1; D_DataStall = 1; D_PC = 32'h3020;
    sc0 = mdl_sc;
    #1;
    n_tests++;
    if (StallFD !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_stallfd got=%b exp=1", StallFD);
    end
    step();
    n_tests++;
    if (E_PC !== 32'h4180 || E_Instr !== 0 || E_BD !== 0 ||
        StallCount !== sc0 + 16'd1) begin
      n_fail++;
      $display("FAIL flush pc=%h instr=%h bd=%b sc=%h exp 4180/0/0/%h",
               E_PC, E_Instr, E_BD, StallCount, sc0 + 16'd1);
    end
    D_DataStall = 0;
    step();
    Req = 0;
    step();
  endtask

  task automatic test_reset_mid_stall();
    quiet();
    rand_d();
    D_DataStall = 1;
    repeat (3) step();
    Reset = 1;
    #1;
    n_tests++;
    if (StallFD !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stallfd got=%b exp=1", StallFD);
    end
    step();
    n_tests++;
    if (E_PC !== 32'h3000 || StallCount !== 16'd0 || E_Valid !== 0) begin
      n_fail++;
      $display("FAIL rst_mid pc=%h sc=%h valid=%b exp 3000/0/0",
               E_PC, StallCount, E_Valid);
    end
    quiet();
    rand_d();
    D_MDType = 0;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      rand_d();
      Reset       = ($urandom_range(0, 29) == 0);
      Req         = ($urandom_range(0, 7) == 0);
      D_DataStall = ($urandom_range(0, 3) == 0);
      E_Start     = ($urandom_range(0, 5) == 0);
      E_Busy      = ($urandom_range(0, 2) == 0);
      step();
    end
    quiet();
  endtask

  task automatic test_saturation();
    quiet();
    Reset = 1;
    step();
    Reset = 0;
    D_DataStall = 1;
    repeat (65534) step();
    n_tests++;
    if (StallCount !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sat_pre got=%h exp=fffe", StallCount);
    end
    repeat (6) step();
    n_tests++;
    if (StallCount !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold got=%h exp=ffff", StallCount);
    end
    quiet();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mdl_sc  = 16'd0;
    quiet();
    rand_d();
    Reset = 1;
    test_reset();
    test_capture();
    test_md_stall();
    test_stall_release();
    test_busy_bypass();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    test_saturation();
    #10;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain left=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
